// File: rtl/updown_cnt_sequencer.sv
// updown_cnt_sequencer: command-driven controller for an up/down counter.
// Accepts {direction, length} run commands into a small FIFO. It drives count_en
// and up_down so the counter counts exactly <length> enabled cycles in the
// requested direction. Then it starts the next queued run.
module updown_cnt_sequencer #(
  parameter int LEN_W  = 8,
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_dir,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     pause,
  input  logic                     abort,
  output logic                     count_en,
  output logic                     up_down,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         run_cnt,
  output logic [$clog2(QDEPTH):0]  cmd_level
);

  localparam int PTR_W = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               dir_q, dir_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

  logic               fifo_dir_q [QDEPTH];
  logic [LEN_W-1:0]   fifo_len_q [QDEPTH];

  logic [PTR_W:0]     level;
  logic               full;
  logic               push;
  logic               pop;
  logic               head_dir;
  logic [LEN_W-1:0]   head_len;

  // FIFO occupancy and the handshake; a pop this cycle only frees a slot next cycle
  always_comb begin
    level     = wr_ptr_q - rd_ptr_q;
    full      = (level == (PTR_W+1)'(QDEPTH));
    cmd_ready = ~full & ~abort & reset_n;
    push      = cmd_valid & cmd_ready;
    head_dir  = fifo_dir_q[rd_ptr_q[PTR_W-1:0]];
    head_len  = fifo_len_q[rd_ptr_q[PTR_W-1:0]];
  end

  // Next-state logic: abort overrides everything, otherwise walk IDLE -> RUN -> DONE
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    dir_d     = dir_q;
    pop       = 1'b0;
    wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d  = rd_ptr_q;
    if (abort) begin
      state_d   = IDLE;
      run_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level != '0) begin
            pop       = 1'b1;
            dir_d     = head_dir;
            run_cnt_d = head_len;
            state_d   = (head_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (!pause) begin
            run_cnt_d = run_cnt_q - LEN_W'(1);
            if (run_cnt_q == LEN_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end
  end

  // Controller state, direction, remaining count and FIFO pointers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      dir_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      dir_q     <= dir_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Command storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dir_q[wr_ptr_q[PTR_W-1:0]] <= cmd_dir;
      fifo_len_q[wr_ptr_q[PTR_W-1:0]] <= cmd_len;
    end
  end

  // Counter controls and status; count_en drops in the abort cycle itself
  always_comb begin
    count_en  = (state_q == RUN) & ~pause & ~abort;
    up_down   = dir_q;
    done      = (state_q == DONE);
    busy      = (state_q != IDLE) | (level != '0);
    run_cnt   = run_cnt_q;
    cmd_level = level;
  end

endmodule

// File: tb/tb_updown_cnt_sequencer.sv
// Testbench for updown_cnt_sequencer: directed scenarios plus a randomized phase.
// It uses a run scoreboard and a local model of the 8-bit up/down counter.
module tb_updown_cnt_sequencer;

  localparam int LEN_W  = 9;
  localparam int QDEPTH = 4;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [LEN_W-1:0] cmd_len;
  logic             pause;
  logic             abort;
  logic             count_en;
  logic             up_down;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] run_cnt;
  logic [2:0]       cmd_level;

  // 9-bit lengths so the 300-cycle run of the queue scenario fits
  updown_cnt_sequencer #(.LEN_W(LEN_W), .QDEPTH(QDEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .pause     (pause),
    .abort     (abort),
    .count_en  (count_en),
    .up_down   (up_down),
    .busy      (busy),
    .done      (done),
    .run_cnt   (run_cnt),
    .cmd_level (cmd_level)
  );

  typedef struct {
    logic dir;
    int   len;
  } run_t;

  run_t       exp_q[$];
  int         n_checks;
  int         n_fail;
  int         n_done;
  int         exp_ctr;
  logic [7:0] ctr;
  logic       ctr_clr;

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Behavioural 8-bit up/down counter driven by the sequencer outputs
  always @(posedge clk) begin
    if (ctr_clr) ctr <= 8'd0;
    else if (count_en) ctr <= up_down ? ctr + 8'd1 : ctr - 8'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one command starting now (caller aligned just after a rising edge)
  task automatic applyStimulus(input logic dir, input int len);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_len   = LEN_W'(len);
    @(negedge clk);
    while (!cmd_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("push_accept", 0, 1);
    end else begin
      exp_q.push_back('{dir, len});
      exp_ctr += dir ? len : -len;
    end
    @(posedge clk); #10;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, busy, 0);
    @(posedge clk); #10;
  endtask

  // Scoreboard monitor: counts enabled cycles per run and retires a run on done
  int   en_cnt;
  int   cyc;
  int   last_en;
  bit   gap_pend;
  run_t r;
  initial begin
    en_cnt = 0; cyc = 0; last_en = 0; gap_pend = 0; n_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n || abort) begin
        exp_q.delete();
        en_cnt   = 0;
        gap_pend = 0;
      end else begin
        if (pause) gap_pend = 0;
        if (count_en) begin
          if (exp_q.size() == 0) begin
            checkOutput("count_en_idle", 1, 0);
          end else begin
            if (en_cnt == 0 && gap_pend) begin
              checkOutput("run_gap", cyc - last_en, 3);
              gap_pend = 0;
            end
            checkOutput("up_down_run", up_down, exp_q[0].dir);
            en_cnt++;
            last_en = cyc;
          end
        end
        if (done) begin
          n_done++;
          if (exp_q.size() == 0) begin
            checkOutput("done_spurious", 1, 0);
          end else begin
            r = exp_q.pop_front();
            checkOutput("run_len", en_cnt, r.len);
            en_cnt   = 0;
            gap_pend = (r.len != 0) && (exp_q.size() > 0) && (exp_q[0].len != 0);
          end
        end
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #(100 * 60000);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized command stream
  int base;
  int done0;
  int waited;
  int sent;
  int cycles;
  bit accepted;
  initial begin
    n_checks = 0; n_fail = 0; exp_ctr = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0;
    pause = 1'b0; abort = 1'b0; ctr_clr = 1'b1;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_count_en", count_en, 0);
    checkOutput("rst_up_down", up_down, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_run_cnt", run_cnt, 0);
    checkOutput("rst_cmd_level", cmd_level, 0);
    @(posedge clk); #10;
    reset_n = 1'b1; ctr_clr = 1'b0;
    @(negedge clk);
    checkOutput("rel_cmd_ready", cmd_ready, 1);
    checkOutput("rel_cmd_level", cmd_level, 0);
    @(posedge clk); #10;

    // Single up run of 30
    done0 = n_done;
    applyStimulus(1'b1, 30);
    waitIdle(200, "single_idle");
    checkOutput("single_ctr", ctr, 32'(8'(exp_ctr)));
    checkOutput("single_done_cnt", n_done - done0, 1);
    checkOutput("single_up_down_hold", up_down, 1);

    // Pause for five cycles starting three cycles into a run of 20
    applyStimulus(1'b1, 20);
    waited = 0;
    @(negedge clk);
    while (!count_en && waited < 10) begin @(negedge clk); waited++; end
    checkOutput("pause_first_run_cnt", run_cnt, 20);
    repeat (3) @(posedge clk);
    #10 pause = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("pause_run_cnt", run_cnt, 17);
      checkOutput("pause_count_en", count_en, 0);
      @(posedge clk);
    end
    #10 pause = 1'b0;
    waitIdle(200, "pause_idle");
    checkOutput("pause_ctr", ctr, 32'(8'(exp_ctr)));

    // Fill the queue back-to-back; the sixth push stalls until a slot frees
    done0 = n_done;
    applyStimulus(1'b1, 300);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 3);
    checkOutput("full_cmd_ready", cmd_ready, 0);
    checkOutput("full_cmd_level", cmd_level, 4);
    checkOutput("full_busy", busy, 1);
    applyStimulus(1'b1, 2);
    waitIdle(1000, "queue_idle");
    checkOutput("queue_ctr", ctr, 32'(8'(exp_ctr)));
    checkOutput("queue_done_cnt", n_done - done0, 6);

    // Abort at run_cnt 25 while a second command waits; push during abort refused
    base  = exp_ctr;
    done0 = n_done;
    applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 50);
    waited = 0;
    @(negedge clk);
    while (!(count_en && run_cnt == 26) && waited < 100) begin @(negedge clk); waited++; end
    @(posedge clk); #10;
    abort = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = LEN_W'(9);
    @(negedge clk);
    checkOutput("abort_count_en", count_en, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 0);
    @(posedge clk); #10;
    abort = 1'b0; cmd_valid = 1'b0;
    exp_ctr = base - 25;
    @(negedge clk);
    checkOutput("abort_cmd_level", cmd_level, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_run_cnt", run_cnt, 0);
    checkOutput("abort_after_count_en", count_en, 0);
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", n_done - done0, 0);
    checkOutput("abort_ctr", ctr, 32'(8'(exp_ctr)));
    @(posedge clk); #10;

    // Synchronous reset in the middle of a run of 100
    applyStimulus(1'b1, 100);
    waited = 0;
    @(negedge clk);
    while (!(count_en && run_cnt == 61) && waited < 200) begin @(negedge clk); waited++; end
    @(posedge clk); #10;
    reset_n = 1'b0;
    @(posedge clk); #10;
    checkOutput("mrst_count_en", count_en, 0);
    checkOutput("mrst_up_down", up_down, 1);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_done", done, 0);
    checkOutput("mrst_run_cnt", run_cnt, 0);
    checkOutput("mrst_cmd_level", cmd_level, 0);
    checkOutput("mrst_cmd_ready", cmd_ready, 0);
    reset_n = 1'b1;
    exp_ctr = int'(ctr);
    applyStimulus(1'b0, 7);
    waitIdle(100, "mrst_idle");
    checkOutput("mrst_ctr", ctr, 32'(8'(exp_ctr)));

    // Randomized commands with random pause and idle gaps
    sent = 0; cycles = 0;
    while (sent < 25 && cycles < 5000) begin
      accepted = 1'b0;
      pause = ($urandom_range(0, 4) == 0);
      if (!cmd_valid && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_len   = LEN_W'($urandom_range(0, 12));
      end
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{cmd_dir, int'(cmd_len)});
        exp_ctr += cmd_dir ? int'(cmd_len) : -int'(cmd_len);
        accepted = 1'b1;
        sent++;
      end
      @(posedge clk); #10;
      if (accepted) cmd_valid = 1'b0;
      cycles++;
    end
    pause = 1'b0; cmd_valid = 1'b0;
    checkOutput("rand_sent", sent, 25);
    waitIdle(2000, "rand_idle");
    checkOutput("rand_ctr", ctr, 32'(8'(exp_ctr)));
    checkOutput("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
